// File: rtl/bcd_wrap_divider_if.sv
// Digit-in / carry-out bundle between the mod-10 counter and the wrap divider.
// master drives digit_i/clr_err_i; slave returns carry/tens/tc/div/seq_err.
interface bcd_wrap_divider_if;
    logic [3:0] digit_i;
    logic       clr_err_i;
    logic       carry_o;
    logic [3:0] tens_o;
    logic       tc_o;
    logic       div_o;
    logic       seq_err_o;

    modport master (
        output digit_i,
        output clr_err_i,
        input  carry_o,
        input  tens_o,
        input  tc_o,
        input  div_o,
        input  seq_err_o
    );

    modport slave (
        input  digit_i,
        input  clr_err_i,
        output carry_o,
        output tens_o,
        output tc_o,
        output div_o,
        output seq_err_o
    );
endinterface

// File: rtl/bcd_wrap_divider.sv
// Wrap divider behind a mod-10 counter: carry per 9->0, mod-TENS_MOD tens,
// tc/div per tens wrap, sticky step-sequence error.
// Ports: clk_i, rst_n_i (async low), bus (slave): digit_i, clr_err_i in;
//        carry_o, tens_o, tc_o, div_o, seq_err_o out.
module bcd_wrap_divider #(
    parameter int unsigned TENS_MOD = 10
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    bcd_wrap_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        S_INIT,
        S_TRACK,
        S_ERR
    } state_t;

    localparam logic [3:0] TENS_LAST = 4'(TENS_MOD - 1);
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] prev_q;
    logic       carry_q;
    logic       carry_d;
    logic       tc_q;
    logic       tc_d;
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic       div_q;
    logic       div_d;
    logic       err_q;
    logic       err_d;

    logic       digit_ok;
    logic       step_hold;
    logic       step_inc;
    logic       step_wrap;
    logic       step_ok;
    logic       tens_wrap;

    // Step classification against the digit seen on the previous edge.
    assign digit_ok  = (bus.digit_i <= DIGIT_MAX);
    assign step_hold = (bus.digit_i == prev_q);
    assign step_inc  = (prev_q < DIGIT_MAX)
                     && (bus.digit_i == prev_q + 4'd1);
    assign step_wrap = (prev_q == DIGIT_MAX)
                     && (bus.digit_i == 4'd0);
    assign step_ok   = digit_ok
                     && (step_hold || step_inc || step_wrap);
    assign tens_wrap = (tens_q == TENS_LAST);

    always_comb begin
        state_d = state_q;
        carry_d = 1'b0;
        tc_d    = 1'b0;
        tens_d  = tens_q;
        div_d   = div_q;
        err_d   = err_q;

        unique case (state_q)
            S_INIT: begin
                // No previous digit to compare against yet.
                if (digit_ok) begin
                    state_d = S_TRACK;
                end else begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_TRACK: begin
                // An illegal step beats both a wrap and clr_err_i.
                if (!step_ok) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (step_wrap) begin
                    carry_d = 1'b1;
                    if (tens_wrap) begin
                        tens_d = 4'd0;
                        tc_d   = 1'b1;
                        div_d  = ~div_q;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end
            end
            S_ERR: begin
                // Counting stays frozen until software clears the flag.
                if (bus.clr_err_i) begin
                    state_d = S_INIT;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_INIT;
            prev_q  <= 4'd0;
            carry_q <= 1'b0;
            tc_q    <= 1'b0;
            tens_q  <= 4'd0;
            div_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.digit_i;
            carry_q <= carry_d;
            tc_q    <= tc_d;
            tens_q  <= tens_d;
            div_q   <= div_d;
            err_q   <= err_d;
        end
    end

    assign bus.carry_o   = carry_q;
    assign bus.tens_o    = tens_q;
    assign bus.tc_o      = tc_q;
    assign bus.div_o     = div_q;
    assign bus.seq_err_o = err_q;

endmodule

// File: tb/tb_bcd_wrap_divider.sv
// Bench for bcd_wrap_divider: wrap-count model, per-cycle compare,
// directed scenarios with literal pins, then a random digit walk.
module tb_bcd_wrap_divider;

    localparam int TM = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    bcd_wrap_divider_if bus();

    bcd_wrap_divider #(.TENS_MOD(TM)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: tracking flags plus a running count of accepted wraps.
    bit m_seen;
    bit m_err;
    int m_prev;
    int m_wraps;
    bit e_carry;
    bit e_tc;
    bit chk_en = 1'b0;

    int n_carry = 0;
    int n_tc    = 0;
    int cur     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen  = 1'b0;
        m_err   = 1'b0;
        m_prev  = 0;
        m_wraps = 0;
        e_carry = 1'b0;
        e_tc    = 1'b0;
    endtask

    task automatic model_step(input int d, input bit clr);
        bit legal;
        e_carry = 1'b0;
        e_tc    = 1'b0;
        if (m_err) begin
            if (clr) begin
                m_err  = 1'b0;
                m_seen = 1'b0;
            end
        end else if (!m_seen) begin
            if (d > 9) m_err = 1'b1;
            else       m_seen = 1'b1;
        end else begin
            legal = (d <= 9) && (d == m_prev || d == (m_prev + 1) % 10);
            if (!legal) begin
                m_err = 1'b1;
            end else if (m_prev == 9 && d == 0) begin
                m_wraps++;
                e_carry = 1'b1;
                e_tc    = (m_wraps % TM == 0);
            end
        end
        m_prev = d;
    endtask

    // Model advances on every edge the DUT is out of reset.
    initial forever begin
        @(posedge clk);
        if (rst_n) model_step(int'(bus.digit_i), bus.clr_err_i);
    end

    // Per-cycle compare on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("carry", int'(bus.carry_o), int'(e_carry));
            check("tc", int'(bus.tc_o), int'(e_tc));
            check("tens", int'(bus.tens_o), m_wraps % TM);
            check("div", int'(bus.div_o), (m_wraps / TM) % 2);
            check("seq_err", int'(bus.seq_err_o), int'(m_err));
            n_carry += int'(bus.carry_o);
            n_tc    += int'(bus.tc_o);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_carry"}, int'(bus.carry_o), 0);
        check({tag, "_tc"}, int'(bus.tc_o), 0);
        check({tag, "_tens"}, int'(bus.tens_o), 0);
        check({tag, "_div"}, int'(bus.div_o), 0);
        check({tag, "_err"}, int'(bus.seq_err_o), 0);
    endtask

    task automatic apply_reset(input logic [3:0] d);
        @(negedge clk);
        #2;
        bus.digit_i   = d;
        bus.clr_err_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int d, input bit c);
        @(negedge clk);
        bus.digit_i   = 4'(d);
        bus.clr_err_i = c;
        cur = d;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int base_c;
    int base_t;
    int r;

    initial begin
        bus.digit_i   = 4'd0;
        bus.clr_err_i = 1'b0;

        // Reset, then one full decade.
        apply_reset(4'd0);
        base_c = n_carry;
        base_t = n_tc;
        for (int i = 0; i <= 10; i++) step(i % 10, 1'b0);
        settle();
        check("t2_tens", int'(bus.tens_o), 1);
        check("t2_carries", n_carry - base_c, 1);
        check("t2_tc", n_tc - base_t, 0);
        check("t2_model_wraps", m_wraps, 1);

        // 100 legal steps: one full tens cycle.
        apply_reset(4'd0);
        base_c = n_carry;
        base_t = n_tc;
        for (int i = 0; i <= 100; i++) step(i % 10, 1'b0);
        settle();
        check("t3_carries", n_carry - base_c, 10);
        check("t3_tc", n_tc - base_t, 1);
        check("t3_tens", int'(bus.tens_o), 0);
        check("t3_div", int'(bus.div_o), 1);

        // Jump 3->7, frozen wrap, clear and resume.
        apply_reset(4'd0);
        for (int i = 0; i <= 3; i++) step(i, 1'b0);
        step(7, 1'b0);
        settle();
        check("t4_err_set", int'(bus.seq_err_o), 1);
        base_c = n_carry;
        step(8, 1'b0);
        step(9, 1'b0);
        step(0, 1'b0);
        settle();
        check("t4_no_carry", n_carry - base_c, 0);
        step(0, 1'b1);
        settle();
        check("t4_err_clr", int'(bus.seq_err_o), 0);
        base_c = n_carry;
        for (int i = 1; i <= 10; i++) step(i % 10, 1'b0);
        settle();
        check("t4_resume", n_carry - base_c, 1);
        check("t4_tens", int'(bus.tens_o), 1);

        // Hold is legal; out-of-range digit is not.
        apply_reset(4'd0);
        for (int i = 0; i <= 4; i++) step(i, 1'b0);
        base_c = n_carry;
        repeat (3) step(4, 1'b0);
        settle();
        check("t5_hold_err", int'(bus.seq_err_o), 0);
        check("t5_hold_carry", n_carry - base_c, 0);
        step(12, 1'b0);
        settle();
        check("t5_bad_digit", int'(bus.seq_err_o), 1);
        step(12, 1'b1);
        step(5, 1'b0);
        step(6, 1'b0);
        settle();
        check("t5_reinit", int'(bus.seq_err_o), 0);
        // Illegal step with clr on the same edge: error wins.
        step(9, 1'b1);
        settle();
        check("t5_err_wins", int'(bus.seq_err_o), 1);
        step(9, 1'b0);

        // Async reset mid-cycle at tens=5.
        apply_reset(4'd0);
        for (int i = 0; i <= 50; i++) step(i % 10, 1'b0);
        settle();
        check("t6_tens5", int'(bus.tens_o), 5);
        @(posedge clk);
        #3;
        bus.digit_i = 4'd6;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("t6_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(6, 1'b0);
        step(7, 1'b0);
        settle();
        check("t6_first_ok", int'(bus.seq_err_o), 0);

        // Random digit walk, mostly legal.
        apply_reset(4'd0);
        cur = 0;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      step((cur + 1) % 10, 1'b0);
            else if (r < 85) step(cur, 1'b0);
            else if (r < 92) step(int'($urandom_range(0, 15)), 1'b0);
            else             step(cur > 9 ? 0 : cur, 1'b1);
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
